branch_predict_unit: RTL
========================

Name: branch_predict_unit

Overview:
- Next-generation branch unit: keeps the existing EX-stage resolution (PC+Imm, PC+4, JALR target, taken decision) and adds an IF-stage direct-mapped branch target buffer with 2-bit saturating direction counters.
- IF stage queries it each cycle for a predicted next PC.
- EX stage resolves branches/jumps and raises Mispredict with the corrected PC; the table and performance counters update on the clock edge.

Parameters:
- PC_W, 9: PC bit-width. Must satisfy PC_W >= IDX_W+3.
- IDX_W, 4: table index bits. Entries = 2**IDX_W.
- CNT_W, 16: width of each performance counter.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- Clear  in  1  synchronous table invalidate.
- If_PC  in  PC_W  PC being fetched.
- Pred_Taken  out  1  IF prediction: taken.
- Pred_PC  out  PC_W  IF predicted next PC.
- Ex_Valid  in  1  EX stage holds a live (non-bubble) instruction.
- Ex_PC  in  PC_W  PC of the EX instruction.
- Imm  in  32  sign-extended immediate.
- Branch, Jump, JumpR  in  1 each  controller decode (conditional branch / JAL / JALR).
- AluResult  in  32  bit0 = branch condition; rs1+imm for JALR.
- Ex_PredTaken  in  1  Pred_Taken, piped to EX.
- Ex_PredPC  in  PC_W  Pred_PC, piped to EX.
- PC_Imm  out  32  zero-extended Ex_PC + Imm.
- PC_Four  out  32  zero-extended Ex_PC + 4 (link value).
- Redirect_PC  out  32  correct next PC for the EX instruction.
- Mispredict  out  1  flush IF/ID and load Redirect_PC.
- Br_Count  out  CNT_W  resolved control-flow instructions.
- Mis_Count  out  CNT_W  mispredictions.

Behaviour:
- Address fields: index = PC[IDX_W+1:2]; tag = PC[PC_W-1:IDX_W+2].
- Entry contents: valid, tag, target (PC_W bits), ctr (2-bit).
- Lookup (combinational): hit = valid && tag match on If_PC.
  - Pred_Taken = hit && ctr[1].
  - Pred_PC = Pred_Taken ? target : (If_PC+4) truncated to PC_W, wrapping at 2**PC_W.
- Resolution (combinational): extend PC to 32 bits with zeros.
  - ActTaken = Jump || JumpR || (Branch && AluResult[0]).
  - ActTarget = (Branch taken or Jump) ? PC_Imm : JumpR ? {AluResult[31:1],1'b0} : PC_Four.
  - Redirect_PC = ActTaken ? ActTarget : PC_Four.
  - Mispredict = Ex_Valid && ((ActTaken != Ex_PredTaken) || (ActTaken && Ex_PredPC != ActTarget[PC_W-1:0])).
  - Mispredict = 0 whenever Ex_Valid = 0.
- Table update (posedge clk, only when Ex_Valid && (Branch || Jump)), using the Ex_PC entry:
  - Hit, taken: ctr increments, saturating at 3; target <= ActTarget[PC_W-1:0].
  - Hit, not taken: ctr decrements, saturating at 0; target unchanged.
  - Miss, taken: install valid=1, new tag, target; ctr = 2 for Branch, 3 for Jump. Overwrites any prior occupant.
  - Miss, not taken: no change.
- JALR is never installed and is always predicted not-taken, so every JALR mispredicts.
- Same-cycle lookup and update on the same index: lookup sees the pre-update contents (no bypass).
- Clear: on the next edge all valid=0 and all ctr=1. Clear has priority over an update in the same cycle. Perf counters are unaffected.
- Perf counters (posedge):
  - Br_Count += 1 when Ex_Valid && (Branch || Jump || JumpR).
  - Mis_Count += 1 on Mispredict.
  - Both saturate at all-ones, no wrap.
- Reset (reset = 0, asynchronous): all valid=0, ctr=1, target=0; Br_Count = Mis_Count = 0.
  - Consequence: Pred_Taken=0 and Pred_PC=If_PC+4 immediately.
  - A reset asserted mid-update discards that update.
- Latency:
  - Prediction: 0 cycles.
  - Resolution outputs: 0 cycles.
  - A table update is visible to lookups from the cycle after the edge.

Test Plan:
- Reset, If_PC=0x010 -> Pred_Taken=0, Pred_PC=0x014; Br_Count=Mis_Count=0.
- Branch at Ex_PC=0x020, Imm=-8, AluResult=1, Ex_PredTaken=0 -> Mispredict=1, Redirect_PC=0x018, entry installed with ctr=2; next cycle If_PC=0x020 gives Pred_Taken=1, Pred_PC=0x018.
- Same branch resolved not-taken twice -> ctr 2->1->0, Pred_Taken=0 after the first update; Mispredict=1 on the first resolution (predicted taken), 0 on the second.
- JAL at 0x040, Imm=0x100, predicted correctly (Ex_PredPC=0x140) -> Mispredict=0, Br_Count+1; JALR with AluResult=0x0000_0123 -> Redirect_PC=0x122, Mispredict=1, table unchanged.
- Aliasing: install a taken branch at 0x004, then one at 0x044 (same index, different tag) -> lookup at 0x004 misses.
- Clear asserted together with an update; separately, reset asserted mid-sequence; separately, Ex_Valid=0 with Branch=1 -> table empty; counters zero after reset; no update and Mispredict=0 for the Ex_Valid=0 case.

Source files
------------

// File: rtl/branch_predict_unit.sv
// Branch unit: EX-stage branch/jump resolution plus an IF-stage direct-mapped
// branch target buffer with 2-bit saturating direction counters and
// saturating performance counters for resolved branches and mispredictions.
module branch_predict_unit #(
    parameter int unsigned PC_W  = 9,
    parameter int unsigned IDX_W = 4,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Clear,
    input  logic [PC_W-1:0]  If_PC,
    output logic             Pred_Taken,
    output logic [PC_W-1:0]  Pred_PC,
    input  logic             Ex_Valid,
    input  logic [PC_W-1:0]  Ex_PC,
    input  logic [31:0]      Imm,
    input  logic             Branch,
    input  logic             Jump,
    input  logic             JumpR,
    input  logic [31:0]      AluResult,
    input  logic             Ex_PredTaken,
    input  logic [PC_W-1:0]  Ex_PredPC,
    output logic [31:0]      PC_Imm,
    output logic [31:0]      PC_Four,
    output logic [31:0]      Redirect_PC,
    output logic             Mispredict,
    output logic [CNT_W-1:0] Br_Count,
    output logic [CNT_W-1:0] Mis_Count
);

    localparam int unsigned ENTRIES = 2 ** IDX_W;
    localparam int unsigned TAG_W   = PC_W - IDX_W - 2;

    // Table storage
    logic [ENTRIES-1:0] valid_q;
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [PC_W-1:0]    target_q [ENTRIES];
    logic [1:0]         ctr_q    [ENTRIES];

    // Lookup side
    logic [IDX_W-1:0]   lk_idx;
    logic [TAG_W-1:0]   lk_tag;
    logic               lk_hit;

    // Resolution side
    logic [31:0]        ex_pc_ext;
    logic               br_taken;
    logic               act_taken;
    logic [31:0]        act_target;

    // Update side
    logic [IDX_W-1:0]   upd_idx;
    logic [TAG_W-1:0]   upd_tag;
    logic               upd_hit;
    logic               upd_en;
    logic               cf_valid;

    // IF-stage lookup: read pre-update contents, predict taken on counter MSB
    always_comb begin
        lk_idx     = If_PC[IDX_W+1:2];
        lk_tag     = If_PC[PC_W-1:IDX_W+2];
        lk_hit     = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
        Pred_Taken = lk_hit && ctr_q[lk_idx][1];
        Pred_PC    = Pred_Taken ? target_q[lk_idx] : If_PC + PC_W'(4);
    end

    // EX-stage resolution: actual direction/target and misprediction detect
    always_comb begin
        ex_pc_ext = 32'(Ex_PC);
        PC_Imm    = ex_pc_ext + Imm;
        PC_Four   = ex_pc_ext + 32'd4;
        br_taken  = Branch && AluResult[0];
        act_taken = Jump || JumpR || br_taken;
        if (br_taken || Jump) begin
            act_target = PC_Imm;
        end else if (JumpR) begin
            act_target = {AluResult[31:1], 1'b0};
        end else begin
            act_target = PC_Four;
        end
        Redirect_PC = act_taken ? act_target : PC_Four;
        Mispredict  = Ex_Valid &&
                      ((act_taken != Ex_PredTaken) ||
                       (act_taken && (Ex_PredPC != act_target[PC_W-1:0])));
    end

    // Update addressing for the EX instruction's entry
    always_comb begin
        upd_idx  = Ex_PC[IDX_W+1:2];
        upd_tag  = Ex_PC[PC_W-1:IDX_W+2];
        upd_hit  = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
        upd_en   = Ex_Valid && (Branch || Jump);
        cf_valid = Ex_Valid && (Branch || Jump || JumpR);
    end

    // Table state: reset/clear invalidate, otherwise train on resolved B/JAL
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= '0;
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                tag_q[IDX_W'(i)]    <= '0;
                target_q[IDX_W'(i)] <= '0;
                ctr_q[IDX_W'(i)]    <= 2'd1;
            end
        end else if (Clear) begin
            valid_q <= '0;
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                ctr_q[IDX_W'(i)] <= 2'd1;
            end
        end else if (upd_en) begin
            if (upd_hit) begin
                if (act_taken) begin
                    if (ctr_q[upd_idx] != 2'd3) begin
                        ctr_q[upd_idx] <= ctr_q[upd_idx] + 2'd1;
                    end
                    target_q[upd_idx] <= act_target[PC_W-1:0];
                end else if (ctr_q[upd_idx] != 2'd0) begin
                    ctr_q[upd_idx] <= ctr_q[upd_idx] - 2'd1;
                end
            end else if (act_taken) begin
                valid_q[upd_idx]  <= 1'b1;
                tag_q[upd_idx]    <= upd_tag;
                target_q[upd_idx] <= act_target[PC_W-1:0];
                ctr_q[upd_idx]    <= Jump ? 2'd3 : 2'd2;
            end
        end
    end

    // Saturating performance counters, independent of Clear
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            Br_Count  <= '0;
            Mis_Count <= '0;
        end else begin
            if (cf_valid && (Br_Count != '1)) begin
                Br_Count <= Br_Count + CNT_W'(1);
            end
            if (Mispredict && (Mis_Count != '1)) begin
                Mis_Count <= Mis_Count + CNT_W'(1);
            end
        end
    end

endmodule
